// File: rtl/gate_array_pkg.sv
// Shared opcode type, buffer depth and identity-element helper for the gated logic pipe.
package gate_array_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOT  = 3'd6,
    OP_PASS = 3'd7
  } gate_op_e;

  localparam int BUF_DEPTH = 2;
  localparam int MAX_W     = 64;

  // Callers truncate the word to their own operand width.
  function automatic logic [MAX_W-1:0] identity_word(input gate_op_e op);
    return (op == OP_AND || op == OP_NAND) ? {MAX_W{1'b1}} : {MAX_W{1'b0}};
  endfunction

endpackage

// File: rtl/gate_array_pipe_reduce.sv
// Combinational masked bitwise reduction over N_IN operands for one selectable logic function.
module gate_reduce
  import gate_array_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N_IN  = 3
) (
  input  logic [N_IN*WIDTH-1:0] data,
  input  logic [N_IN-1:0]       mask,
  input  gate_op_e              op,
  output logic [WIDTH-1:0]      result
);

  logic [WIDTH-1:0] ident;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] acc_and;
  logic [WIDTH-1:0] acc_or;
  logic [WIDTH-1:0] acc_xor;

  assign ident = WIDTH'(identity_word(op));

  // Identity substitution only has to be right for the family op selects below.
  always_comb begin
    acc_and = '1;
    acc_or  = '0;
    acc_xor = '0;
    opnd    = '0;
    for (int i = 0; i < N_IN; i++) begin
      opnd    = mask[i] ? data[i*WIDTH +: WIDTH] : ident;
      acc_and = acc_and & opnd;
      acc_or  = acc_or | opnd;
      acc_xor = acc_xor ^ opnd;
    end
  end

  always_comb begin
    result = '0;
    case (op)
      OP_AND:  result = acc_and;
      OP_OR:   result = acc_or;
      OP_XOR:  result = acc_xor;
      OP_NAND: result = ~acc_and;
      OP_NOR:  result = ~acc_or;
      OP_XNOR: result = ~acc_xor;
      OP_NOT:  result = ~data[WIDTH-1:0];
      default: result = data[WIDTH-1:0];
    endcase
  end

endmodule

// File: rtl/gate_array_pipe.sv
// Masked multi-operand logic gate with a 2-entry valid/ready output buffer and accept counter.
module gate_array_pipe
  import gate_array_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N_IN  = 3,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_op,
  input  logic [N_IN-1:0]       in_mask,
  input  logic [N_IN*WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_zero,
  output logic [CNT_W-1:0]      op_count
);

  logic [WIDTH-1:0]     result_p0;
  logic                 zero_p0;
  logic [WIDTH-1:0]     buf_data_p1 [BUF_DEPTH];
  logic [BUF_DEPTH-1:0] buf_zero_p1;
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic [1:0]           count;
  logic [1:0]           count_next;
  logic                 accept;
  logic                 pop;

  gate_reduce #(
    .WIDTH (WIDTH),
    .N_IN  (N_IN)
  ) u_reduce (
    .data   (in_data),
    .mask   (in_mask),
    .op     (gate_op_e'(in_op)),
    .result (result_p0)
  );

  assign zero_p0 = (result_p0 == '0);
  assign accept  = in_valid && in_ready;
  assign pop     = out_valid && out_ready;

  always_comb begin
    count_next = count;
    case ({accept, pop})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
  end

  // p0 -> p1: capture the combinational result into the buffer slot
  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      op_count    <= '0;
      buf_zero_p1 <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) buf_data_p1[i] <= '0;
    end else begin
      count     <= count_next;
      in_ready  <= (count_next < 2'(BUF_DEPTH));
      out_valid <= (count_next != 2'd0);
      if (accept) begin
        buf_data_p1[wr_ptr] <= result_p0;
        buf_zero_p1[wr_ptr] <= zero_p0;
        wr_ptr              <= ~wr_ptr;
        op_count            <= op_count + CNT_W'(1);
      end
      if (pop) rd_ptr <= ~rd_ptr;
    end
  end

  assign out_data = buf_data_p1[rd_ptr];
  assign out_zero = buf_zero_p1[rd_ptr];

endmodule
